// File: rtl/rx_pattern_checker_if.sv
// Byte-stream and status bundle between the UART receiver, the pattern checker and the LED/debug logic.
// The master drives received bytes and the error clear; the slave (the checker) drives the status.
interface rx_pattern_checker_if #(
  parameter int ERR_W = 8
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             clr_err;
  logic             locked;
  logic [4:0]       addr;
  logic             match_pulse;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output rx_data, rx_valid, clr_err,
    input  locked, addr, match_pulse, err_pulse, err_count
  );

  modport slave (
    input  rx_data, rx_valid, clr_err,
    output locked, addr, match_pulse, err_pulse, err_count
  );
endinterface

// File: rtl/rx_pattern_checker.sv
// Receive-side checker for the 32-byte UART test pattern: hunts the AA,55 marker, then compares
// each received byte to the fixed pattern and reports lock, match/error pulses and a saturating error count.
module rx_pattern_checker #(
  parameter int ERR_W    = 8,
  parameter int LOSS_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  rx_pattern_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] MARK_HI = 8'hAA;
  localparam logic [7:0] MARK_LO = 8'h55;
  localparam logic [2:0] LOSS    = 3'(LOSS_CNT);

  state_t           state, state_nxt;
  logic [4:0]       addr_q, addr_nxt;
  logic [2:0]       miss_q, miss_nxt;
  logic [ERR_W-1:0] cnt_q, cnt_nxt;
  logic             locked_q, locked_nxt;
  logic             match_q, match_nxt;
  logic             err_q, err_nxt;

  function automatic logic [7:0] pattern_byte(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:  b = 8'h00;  5'd1:  b = 8'h01;  5'd2:  b = 8'h02;  5'd3:  b = 8'h04;
      5'd4:  b = 8'h08;  5'd5:  b = 8'h10;  5'd6:  b = 8'h20;  5'd7:  b = 8'h40;
      5'd8:  b = 8'h80;  5'd9:  b = 8'h80;  5'd10: b = 8'h40;  5'd11: b = 8'h20;
      5'd12: b = 8'h10;  5'd13: b = 8'h08;  5'd14: b = 8'h04;  5'd15: b = 8'h02;
      5'd16: b = 8'h01;  5'd17: b = 8'h00;  5'd18: b = 8'h10;  5'd19: b = 8'h38;
      5'd20: b = 8'h7C;  5'd21: b = 8'hFE;  5'd22: b = 8'hFF;  5'd23: b = 8'h00;
      5'd24: b = 8'hFF;  5'd25: b = 8'hFE;  5'd26: b = 8'h7C;  5'd27: b = 8'h10;
      5'd28: b = 8'hFF;  5'd29: b = 8'h00;  5'd30: b = 8'hAA;  default: b = 8'h55;
    endcase
    return b;
  endfunction

  // Count holds at all-ones instead of wrapping back to zero.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    if (&c) return c;
    return c + ERR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    miss_nxt   = miss_q;
    cnt_nxt    = cnt_q;
    match_nxt  = 1'b0;
    err_nxt    = 1'b0;
    if (bus.rx_valid) begin
      case (state)
        HUNT: begin
          if (bus.rx_data == MARK_HI) state_nxt = SYNC;
        end
        SYNC: begin
          if (bus.rx_data == MARK_LO) begin
            state_nxt = CHECK;
            addr_nxt  = 5'd0;
            miss_nxt  = 3'd0;
          end else if (bus.rx_data != MARK_HI) begin
            state_nxt = HUNT;
          end
        end
        CHECK: begin
          addr_nxt = addr_q + 5'd1;
          if (bus.rx_data == pattern_byte(addr_q)) begin
            match_nxt = 1'b1;
            miss_nxt  = 3'd0;
          end else begin
            err_nxt = 1'b1;
            cnt_nxt = sat_inc(cnt_q);
            // The byte that breaks lock is still counted as an error above.
            if (miss_q + 3'd1 == LOSS) begin
              state_nxt = HUNT;
              addr_nxt  = 5'd0;
              miss_nxt  = 3'd0;
            end else begin
              miss_nxt = miss_q + 3'd1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
    if (bus.clr_err) cnt_nxt = '0;
    locked_nxt = (state_nxt == CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 5'd0;
      miss_q   <= 3'd0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_nxt;
      miss_q   <= miss_nxt;
      cnt_q    <= cnt_nxt;
      locked_q <= locked_nxt;
      match_q  <= match_nxt;
      err_q    <= err_nxt;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.addr        = addr_q;
  assign bus.match_pulse = match_q;
  assign bus.err_pulse   = err_q;
  assign bus.err_count   = cnt_q;

endmodule

// File: tb/tb_rx_pattern_checker.sv
// Bench for rx_pattern_checker: directed vector table, hand-written corner sequences and a
// randomized run against a behavioural model of the pattern hunt/check rules.
module tb_rx_pattern_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_pattern_checker_if #(.ERR_W(8)) ifa ();
  rx_pattern_checker_if #(.ERR_W(2)) ifb ();

  rx_pattern_checker #(.ERR_W(8), .LOSS_CNT(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  rx_pattern_checker #(.ERR_W(2), .LOSS_CNT(7)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic [7:0] pat [32] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
    8'h01, 8'h00, 8'h10, 8'h38, 8'h7C, 8'hFE, 8'hFF, 8'h00,
    8'hFF, 8'hFE, 8'h7C, 8'h10, 8'hFF, 8'h00, 8'hAA, 8'h55};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and sample #1 after the capturing edge.
  task automatic step_a(input logic v, input logic [7:0] d, input logic c);
    ifa.rx_valid = v; ifa.rx_data = d; ifa.clr_err = c;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input logic [7:0] d, input logic c);
    ifb.rx_valid = v; ifb.rx_data = d; ifb.clr_err = c;
    @(posedge clk); #1;
  endtask

  task automatic chk_a(input string nm, input logic lk, input logic [4:0] a,
                       input logic mp, input logic ep, input int cnt);
    chk({nm, ".locked"}, 32'(ifa.locked), 32'(lk));
    chk({nm, ".addr"},   32'(ifa.addr), 32'(a));
    chk({nm, ".match"},  32'(ifa.match_pulse), 32'(mp));
    chk({nm, ".err"},    32'(ifa.err_pulse), 32'(ep));
    chk({nm, ".count"},  32'(ifa.err_count), 32'(cnt));
  endtask

  task automatic chk_b(input string nm, input logic lk, input logic ep, input int cnt);
    chk({nm, ".locked"}, 32'(ifb.locked), 32'(lk));
    chk({nm, ".err"},    32'(ifb.err_pulse), 32'(ep));
    chk({nm, ".count"},  32'(ifb.err_count), 32'(cnt));
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       c;
    logic       lk;
    logic [4:0] a;
    logic       mp;
    logic       ep;
    int         cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic v, input logic [7:0] d, input logic c, input logic lk,
                     input logic [4:0] a, input logic mp, input logic ep, input int cnt);
    vec_t x;
    x.v = v; x.d = d; x.c = c; x.lk = lk; x.a = a; x.mp = mp; x.ep = ep; x.cnt = cnt;
    vt.push_back(x);
  endtask

  // Behavioural model for LOSS_CNT=3, ERR_W=8: lock is "marker seen", position is a plain index.
  bit m_locked, m_seen_aa, m_match, m_err;
  int m_pos, m_miss, m_cnt;

  task automatic model_reset();
    m_locked = 0; m_seen_aa = 0; m_match = 0; m_err = 0;
    m_pos = 0; m_miss = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit c);
    m_match = 0; m_err = 0;
    if (v) begin
      if (m_locked) begin
        if (d == pat[m_pos]) begin
          m_match = 1; m_miss = 0;
        end else begin
          m_err = 1; m_miss++;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        m_pos = (m_pos + 1) % 32;
        if (m_miss == 3) begin
          m_locked = 0; m_pos = 0; m_miss = 0; m_seen_aa = 0;
        end
      end else if (m_seen_aa && d == 8'h55) begin
        m_locked = 1; m_pos = 0; m_miss = 0; m_seen_aa = 0;
      end else begin
        m_seen_aa = (d == 8'hAA);
      end
    end
    if (c) m_cnt = 0;
  endtask

  initial begin
    int nmatch;
    logic v, c;
    logic [7:0] d;
    int r;

    ifa.rx_valid = 0; ifa.rx_data = 0; ifa.clr_err = 0;
    ifb.rx_valid = 0; ifb.rx_data = 0; ifb.clr_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_a("reset_a", 0, 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0);
    rst = 0;

    // Lock, single error, idle, clear, loss of lock, relock.
    add(1, 8'h11, 0, 0, 0, 0, 0, 0);
    add(1, 8'hAA, 0, 0, 0, 0, 0, 0);
    add(1, 8'h55, 0, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 1, 1, 1, 0, 0);
    add(1, 8'h01, 0, 1, 2, 1, 0, 0);
    add(1, 8'h02, 0, 1, 3, 1, 0, 0);
    add(1, 8'h04, 0, 1, 4, 1, 0, 0);
    add(1, 8'h09, 0, 1, 5, 0, 1, 1);
    add(1, 8'h10, 0, 1, 6, 1, 0, 1);
    add(0, 8'h33, 0, 1, 6, 0, 0, 1);
    add(0, 8'h00, 1, 1, 6, 0, 0, 0);
    add(1, 8'h00, 0, 1, 7, 0, 1, 1);
    add(1, 8'h00, 0, 1, 8, 0, 1, 2);
    add(1, 8'h00, 0, 0, 0, 0, 1, 3);
    add(1, 8'h00, 0, 0, 0, 0, 0, 3);
    add(1, 8'h55, 0, 0, 0, 0, 0, 3);
    add(1, 8'hAA, 0, 0, 0, 0, 0, 3);
    add(1, 8'h55, 0, 1, 0, 0, 0, 3);
    foreach (vt[i]) begin
      step_a(vt[i].v, vt[i].d, vt[i].c);
      chk_a($sformatf("vec%0d", i), vt[i].lk, vt[i].a, vt[i].mp, vt[i].ep, vt[i].cnt);
    end

    // Wrap: 64 correct bytes, address rolls 31->0 twice.
    nmatch = 0;
    for (int i = 0; i < 64; i++) begin
      step_a(1, pat[i % 32], 0);
      if (ifa.match_pulse === 1'b1) nmatch++;
      chk_a($sformatf("wrap%0d", i), 1, 5'((i + 1) % 32), 1, 0, 3);
    end
    chk("wrap.matches", 32'(nmatch), 32'd64);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    step_a(1, 8'hEE, 0);
    step_a(1, 8'hEE, 0);
    chk_a("pre_rst", 1, 2, 0, 1, 5);
    step_a(0, 8'h00, 0);
    #3 rst = 1;
    #1 chk_a("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 0;
    step_a(1, 8'hAA, 0);
    step_a(1, 8'h55, 0);
    chk_a("post_rst_lock", 1, 0, 0, 0, 0);
    step_a(0, 8'h00, 0);

    // Saturation and clear priority with ERR_W=2, LOSS_CNT=7.
    step_b(1, 8'hAA, 0);
    step_b(1, 8'h55, 0);
    chk_b("b_lock", 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step_b(1, 8'hFF, 0);
      chk_b($sformatf("b_miss%0d", i + 1), 1, 1, (i + 1 > 3) ? 3 : i + 1);
    end
    step_b(1, 8'hFF, 1);
    chk_b("b_clr_miss6", 1, 1, 0);
    step_b(1, 8'hFF, 0);
    chk_b("b_miss7_loss", 0, 1, 1);
    step_b(1, 8'hAA, 0);
    step_b(1, 8'hAA, 0);
    chk_b("b_sync_aa", 0, 0, 1);
    step_b(1, 8'h55, 0);
    chk_b("b_relock", 1, 0, 1);
    step_b(0, 8'h00, 0);

    // Randomized run against the model.
    #3 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 9);
      if (m_locked) d = (r < 7) ? pat[m_pos] : 8'($urandom);
      else          d = (r < 4) ? 8'hAA : (r < 7) ? 8'h55 : 8'($urandom);
      model_step(v, d, c);
      step_a(v, d, c);
      chk_a($sformatf("rnd%0d", i), m_locked, 5'(m_pos), m_match, m_err, m_cnt);
    end
    step_a(0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
